// File: rtl/combo_lock_if.sv
`default_nettype none
// ============================================================================
// combo_lock_if : button pulses in, display/status fields out
// Rev 1.0
// ============================================================================
interface combo_lock_if;
  logic        btn_inc;
  logic        btn_dec;
  logic        btn_enter;
  logic        btn_lock;
  logic        btn_prog;
  logic [3:0]  digit;
  logic [15:0] entry;
  logic [1:0]  digit_idx;
  logic [2:0]  state;
  logic        unlocked;
  logic        alarm;
  logic [1:0]  fail_count;

  modport master (
    output btn_inc, btn_dec, btn_enter, btn_lock, btn_prog,
    input  digit, entry, digit_idx, state, unlocked, alarm, fail_count
  );

  modport slave (
    input  btn_inc, btn_dec, btn_enter, btn_lock, btn_prog,
    output digit, entry, digit_idx, state, unlocked, alarm, fail_count
  );
endinterface
`default_nettype wire

// File: rtl/combo_lock_sequencer.sv
`default_nettype none
// ============================================================================
// combo_lock_sequencer : digit entry, code check, lockout and reprogramming
// Rev 1.0
// ============================================================================
module combo_lock_sequencer #(
  parameter int          MAX_FAIL     = 3,
  parameter int          LOCKOUT_CYC  = 100000000,
  parameter logic [15:0] DEFAULT_CODE = 16'h1234
) (
  input  logic         clk,
  input  logic         rst,
  combo_lock_if.slave  bus
);

  localparam int TIMER_W = $clog2(LOCKOUT_CYC);
  localparam logic [TIMER_W-1:0] c_TIMER_LOAD = TIMER_W'(LOCKOUT_CYC - 1);
  localparam logic [1:0]         c_MAX_FAIL   = 2'(MAX_FAIL);

  typedef enum logic [2:0] {
    LOCKED  = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    PROG    = 3'd3,
    LOCKOUT = 3'd4
  } stateT;

  stateT              r_state,     w_stateNext;
  logic [3:0]         r_digit,     w_digitNext;
  logic [15:0]        r_entry,     w_entryNext;
  logic [1:0]         r_digitIdx,  w_digitIdxNext;
  logic [1:0]         r_failCount, w_failCountNext;
  logic [15:0]        r_code,      w_codeNext;
  logic [TIMER_W-1:0] r_timer,     w_timerNext;
  logic [15:0]        w_shifted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= LOCKED;
      r_digit     <= 4'd0;
      r_entry     <= 16'd0;
      r_digitIdx  <= 2'd0;
      r_failCount <= 2'd0;
      r_code      <= DEFAULT_CODE;
      r_timer     <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_digit     <= w_digitNext;
      r_entry     <= w_entryNext;
      r_digitIdx  <= w_digitIdxNext;
      r_failCount <= w_failCountNext;
      r_code      <= w_codeNext;
      r_timer     <= w_timerNext;
    end
  end

  // The pre-edit digit is shifted, so inc/dec coinciding with enter is dropped.
  assign w_shifted = {r_entry[11:0], r_digit};

  always_comb begin
    w_stateNext     = r_state;
    w_digitNext     = r_digit;
    w_entryNext     = r_entry;
    w_digitIdxNext  = r_digitIdx;
    w_failCountNext = r_failCount;
    w_codeNext      = r_code;
    w_timerNext     = r_timer;

    case (r_state)
      LOCKED, PROG: begin
        if (bus.btn_lock) begin
          w_stateNext    = LOCKED;
          w_digitNext    = 4'd0;
          w_entryNext    = 16'd0;
          w_digitIdxNext = 2'd0;
        end else if (bus.btn_enter) begin
          w_digitNext    = 4'd0;
          w_digitIdxNext = r_digitIdx + 2'd1;
          w_entryNext    = w_shifted;
          if (r_digitIdx == 2'd3) begin
            if (r_state == PROG) begin
              w_codeNext  = w_shifted;
              w_entryNext = 16'd0;
              w_stateNext = OPEN;
            end else begin
              w_stateNext = CHECK;
            end
          end
        end else if (bus.btn_inc && !bus.btn_dec) begin
          w_digitNext = r_digit + 4'd1;
        end else if (bus.btn_dec && !bus.btn_inc) begin
          w_digitNext = r_digit - 4'd1;
        end
      end

      CHECK: begin
        w_entryNext = 16'd0;
        if (r_entry == r_code) begin
          w_stateNext     = OPEN;
          w_failCountNext = 2'd0;
        end else if (r_failCount + 2'd1 == c_MAX_FAIL) begin
          w_stateNext     = LOCKOUT;
          w_failCountNext = c_MAX_FAIL;
          w_timerNext     = c_TIMER_LOAD;
        end else begin
          w_stateNext     = LOCKED;
          w_failCountNext = r_failCount + 2'd1;
        end
      end

      OPEN: begin
        if (bus.btn_lock) begin
          w_stateNext    = LOCKED;
          w_digitNext    = 4'd0;
          w_entryNext    = 16'd0;
          w_digitIdxNext = 2'd0;
        end else if (bus.btn_prog) begin
          w_stateNext    = PROG;
          w_entryNext    = 16'd0;
          w_digitIdxNext = 2'd0;
        end
      end

      LOCKOUT: begin
        if (r_timer == '0) begin
          w_stateNext     = LOCKED;
          w_failCountNext = 2'd0;
        end else begin
          w_timerNext = r_timer - 1'b1;
        end
      end

      default: w_stateNext = LOCKED;
    endcase
  end

  assign bus.digit      = r_digit;
  assign bus.entry      = r_entry;
  assign bus.digit_idx  = r_digitIdx;
  assign bus.state      = r_state;
  assign bus.unlocked   = (r_state == OPEN) || (r_state == PROG);
  assign bus.alarm      = (r_state == LOCKOUT);
  assign bus.fail_count = r_failCount;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_sequencer.sv
`default_nettype none
// ============================================================================
// tb_combo_lock_sequencer : directed + randomized bench against a digit-level model
// Rev 1.0
// ============================================================================
module tb_combo_lock_sequencer;

  localparam int c_MAX_FAIL = 3;
  localparam int c_LOCKOUT  = 8;
  localparam int c_DEFCODE  = 'h1234;
  localparam int S_LOCKED = 0, S_CHECK = 1, S_OPEN = 2, S_PROG = 3, S_LOCKOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  combo_lock_if bus ();

  combo_lock_sequencer #(
    .MAX_FAIL    (c_MAX_FAIL),
    .LOCKOUT_CYC (c_LOCKOUT),
    .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: digits tracked as integers, entry as a base-16 number.
  int mState, mDigit, mEntry, mCount, mFail, mCode, mRemain;

  task automatic modelReset();
    mState = S_LOCKED; mDigit = 0; mEntry = 0; mCount = 0;
    mFail = 0; mCode = c_DEFCODE; mRemain = 0;
  endtask

  task automatic modelStep(input bit inc, dec, ent, lck, prg);
    case (mState)
      S_LOCKED, S_PROG: begin
        if (lck) begin
          mState = S_LOCKED; mDigit = 0; mEntry = 0; mCount = 0;
        end else if (ent) begin
          mEntry = (mEntry * 16 + mDigit) % 65536;
          mDigit = 0;
          mCount = mCount + 1;
          if (mCount == 4) begin
            mCount = 0;
            if (mState == S_PROG) begin
              mCode = mEntry; mEntry = 0; mState = S_OPEN;
            end else mState = S_CHECK;
          end
        end else if (inc != dec) begin
          mDigit = inc ? (mDigit + 1) % 16 : (mDigit + 15) % 16;
        end
      end
      S_CHECK: begin
        if (mEntry == mCode) begin
          mState = S_OPEN; mFail = 0;
        end else if (mFail + 1 >= c_MAX_FAIL) begin
          mState = S_LOCKOUT; mFail = c_MAX_FAIL; mRemain = c_LOCKOUT;
        end else begin
          mState = S_LOCKED; mFail = mFail + 1;
        end
        mEntry = 0;
      end
      S_OPEN: begin
        if (lck) begin
          mState = S_LOCKED; mDigit = 0; mEntry = 0; mCount = 0;
        end else if (prg) begin
          mState = S_PROG; mEntry = 0; mCount = 0;
        end
      end
      default: begin
        mRemain = mRemain - 1;
        if (mRemain == 0) begin
          mState = S_LOCKED; mFail = 0;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".state"},    16'(bus.state),      16'(mState));
    chk({tag, ".digit"},    16'(bus.digit),      16'(mDigit));
    chk({tag, ".entry"},    bus.entry,           16'(mEntry));
    chk({tag, ".idx"},      16'(bus.digit_idx),  16'(mCount));
    chk({tag, ".fail"},     16'(bus.fail_count), 16'(mFail));
    chk({tag, ".unlocked"}, 16'(bus.unlocked),   16'((mState == S_OPEN) || (mState == S_PROG)));
    chk({tag, ".alarm"},    16'(bus.alarm),      16'(mState == S_LOCKOUT));
  endtask

  task automatic cycle(input bit inc, dec, ent, lck, prg, input string tag);
    @(negedge clk);
    bus.btn_inc = inc; bus.btn_dec = dec; bus.btn_enter = ent;
    bus.btn_lock = lck; bus.btn_prog = prg;
    @(posedge clk);
    #1;
    bus.btn_inc = 0; bus.btn_dec = 0; bus.btn_enter = 0;
    bus.btn_lock = 0; bus.btn_prog = 0;
    modelStep(inc, dec, ent, lck, prg);
    checkAll(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, tag);
  endtask

  task automatic enterDigit(input int d, input string tag);
    int steps;
    steps = (d - mDigit + 16) % 16;
    for (int i = 0; i < steps; i++) cycle(1, 0, 0, 0, 0, tag);
    cycle(0, 0, 1, 0, 0, tag);
  endtask

  task automatic enterCode(input logic [15:0] code, input string tag);
    for (int k = 3; k >= 0; k--) begin
      logic [15:0] c;
      c = code >> (4 * k);
      enterDigit(int'(c[3:0]), tag);
    end
  endtask

  task automatic asyncReset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.btn_inc = 0; bus.btn_dec = 0; bus.btn_enter = 0;
    bus.btn_lock = 0; bus.btn_prog = 0;
    modelReset();
    #2;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b1;

    // Correct code: state goes LOCKED -> CHECK -> OPEN.
    enterCode(16'h1234, "open1234");
    chk("preCheckEntry", bus.entry, 16'h1234);
    chk("preCheckState", 16'(bus.state), 16'(S_CHECK));
    idle(1, "openResult");
    chk("openUnlocked", 16'(bus.unlocked), 16'd1);
    cycle(0, 0, 1, 0, 0, "openIgnoreEnter");
    cycle(0, 0, 0, 1, 0, "relock");

    // Wrap and simultaneous buttons.
    cycle(0, 1, 0, 0, 0, "decWrap");
    chk("decWrapDigit", 16'(bus.digit), 16'hF);
    cycle(1, 0, 0, 0, 0, "incWrap");
    cycle(1, 1, 0, 0, 0, "incDecSame");
    enterDigit(5, "toFive");
    cycle(0, 0, 0, 1, 0, "clear5");
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, "inc5");
    cycle(1, 0, 1, 0, 0, "enterPlusInc");
    chk("enterPlusIncLow", 16'(bus.entry[3:0]), 16'd5);
    cycle(0, 0, 0, 1, 0, "clearPartial");

    // Three wrong codes then lockout with buttons ignored.
    for (int a = 0; a < 3; a++) begin
      enterCode(16'h0000, "wrong");
      idle(1, "wrongResult");
    end
    chk("lockoutAlarm", 16'(bus.alarm), 16'd1);
    for (int i = 0; i < c_LOCKOUT; i++)
      cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), "lockoutDwell");
    chk("lockoutExit", 16'(bus.state), 16'(S_LOCKED));

    // Reprogram to ABCD.
    enterCode(16'h1234, "unlockForProg");
    idle(1, "unlockForProgRes");
    cycle(0, 0, 0, 0, 1, "prog");
    enterCode(16'hABCD, "progAbcd");
    cycle(0, 0, 0, 1, 0, "lockAfterProg");
    enterCode(16'h1234, "oldCode");
    idle(1, "oldCodeRes");
    enterCode(16'hABCD, "newCode");
    idle(1, "newCodeRes");
    chk("newCodeOpen", 16'(bus.state), 16'(S_OPEN));

    // Abort paths, with lock winning over prog in OPEN.
    cycle(0, 0, 0, 1, 1, "lockBeatsProg");
    enterDigit(7, "partA");
    enterDigit(3, "partB");
    cycle(0, 0, 1, 1, 0, "lockBeatsEnter");
    asyncReset("resetForAbort");
    enterCode(16'h1234, "unlockAbort");
    idle(1, "unlockAbortRes");
    cycle(0, 0, 0, 0, 1, "progAbort");
    enterDigit(9, "p1"); enterDigit(8, "p2"); enterDigit(7, "p3");
    cycle(0, 0, 0, 1, 0, "abortProg");
    enterCode(16'h1234, "codeKept");
    idle(1, "codeKeptRes");

    // Async reset inside PROG and inside LOCKOUT.
    cycle(0, 0, 0, 0, 1, "progAgain");
    enterDigit(4, "progPartial");
    asyncReset("resetInProg");
    for (int a = 0; a < 3; a++) begin
      enterCode(16'h5555, "wrong2");
      idle(1, "wrong2Res");
    end
    idle(3, "midLockout");
    asyncReset("resetInLockout");
    enterCode(16'h1234, "defaultRestored");
    idle(1, "defaultRestoredRes");
    cycle(0, 0, 0, 1, 0, "relock2");

    // Randomized code attempts and occasional reprogramming.
    for (int a = 0; a < 20; a++) begin
      logic [15:0] guess;
      guess = ($urandom_range(0, 1) == 1) ? 16'(mCode) : 16'($urandom);
      enterCode(guess, "rndAttempt");
      idle(1, "rndResult");
      if (mState == S_OPEN) begin
        if ($urandom_range(0, 1) == 1) begin
          cycle(0, 0, 0, 0, 1, "rndProg");
          enterCode(16'($urandom), "rndNewCode");
        end
        cycle(0, 0, 0, 1, 0, "rndLock");
      end
      if (mState == S_LOCKOUT) idle(c_LOCKOUT, "rndLockout");
    end

    // Free-running random button pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) asyncReset("rndReset");
      cycle(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 3) == 0),
            bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 9) == 0),
            bit'($urandom_range(0, 5) == 0), "rndBtn");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
